// File: rtl/aes_ctr_sched.sv
// aes_ctr_sched
//   Counter owner and sequencer for the AES CTR-mode increment path.
//   Holds the full counter and serialises software loads and cipher-core
//   increment requests. An increment is delegated to a slice-wise increment
//   FSM: this block starts it, serves the selected slice, stores each
//   written-back slice verbatim and acknowledges once every slice has been
//   rewritten in order. Any deviation from that write sequence, or an alert
//   from the FSM, parks the block in a terminal error state with a sticky
//   alert.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   load_i, load_data_i  counter load request and value
//   load_ready_o         load is accepted this cycle (idle only)
//   incr_req_i           level increment request, held until incr_ack_o
//   incr_ack_o           one-cycle pulse, ctr_o already incremented
//   ctr_o                current counter value
//   busy_o               increment in flight
//   fsm_incr_o           start pulse to the increment FSM
//   fsm_ready_i          increment FSM idle
//   fsm_slice_idx_i      slice selected by the FSM
//   fsm_slice_o          counter slice at fsm_slice_idx_i
//   fsm_slice_i          incremented slice from the FSM
//   fsm_we_i             slice write enable
//   fsm_alert_i          alert raised by the increment FSM
//   alert_o              sticky fatal alert
module aes_ctr_sched #(
  parameter int unsigned NumSlices = 8,
  parameter int unsigned SliceSize = 16,
  localparam int unsigned CtrWidth = NumSlices * SliceSize,
  localparam int unsigned IdxW     = $clog2(NumSlices)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [CtrWidth-1:0]  load_data_i,
  output logic                 load_ready_o,
  input  logic                 incr_req_i,
  output logic                 incr_ack_o,
  output logic [CtrWidth-1:0]  ctr_o,
  output logic                 busy_o,
  output logic                 fsm_incr_o,
  input  logic                 fsm_ready_i,
  input  logic [IdxW-1:0]      fsm_slice_idx_i,
  output logic [SliceSize-1:0] fsm_slice_o,
  input  logic [SliceSize-1:0] fsm_slice_i,
  input  logic                 fsm_we_i,
  input  logic                 fsm_alert_i,
  output logic                 alert_o
);

  localparam int unsigned CntW = IdxW + 1;
  // Write count that marks a fully rewritten counter.
  localparam logic [CntW-1:0] WcntFull = CntW'(NumSlices);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StError = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic [NumSlices-1:0][SliceSize-1:0] ctr_q, ctr_d;
  logic [CntW-1:0]                    wcnt_q, wcnt_d;

  logic wcnt_full;
  logic we_in_order;
  logic we_bad;

  assign wcnt_full   = (wcnt_q == WcntFull);
  // A write is legal only while slices remain and it targets the next one.
  assign we_in_order = !wcnt_full && (fsm_slice_idx_i == wcnt_q[IdxW-1:0]);
  assign we_bad      = fsm_we_i && !we_in_order;

  assign ctr_o       = ctr_q;
  assign fsm_slice_o = ctr_q[fsm_slice_idx_i];
  assign alert_o     = (state_q == StError);

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    wcnt_d       = wcnt_q;
    load_ready_o = 1'b0;
    busy_o       = 1'b0;
    fsm_incr_o   = 1'b0;
    incr_ack_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        load_ready_o = 1'b1;
        // Any FSM write or alert while idle is a protocol violation.
        if (fsm_alert_i || fsm_we_i) begin
          state_d = StError;
        end
        if (load_i) begin
          ctr_d = load_data_i;
        end else if (incr_req_i && fsm_ready_i && !fsm_alert_i && !fsm_we_i) begin
          fsm_incr_o = 1'b1;
          wcnt_d     = '0;
          state_d    = StBusy;
        end
      end

      StBusy: begin
        busy_o = 1'b1;
        if (fsm_alert_i || we_bad) begin
          state_d = StError;
        end else begin
          if (fsm_we_i) begin
            ctr_d[fsm_slice_idx_i] = fsm_slice_i;
            wcnt_d                 = wcnt_q + CntW'(1);
          end
          // FSM back to idle: only a complete, in-order rewrite is a success.
          if (fsm_ready_i) begin
            if (wcnt_full) begin
              incr_ack_o = 1'b1;
              state_d    = StIdle;
            end else begin
              state_d = StError;
            end
          end
        end
      end

      StError: begin
        state_d = StError;
      end

      default: begin
        state_d = StError;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule
